// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Handshake/control bundle between the pipeline datapath and
//               the hazard controller.
//               master : datapath side; drives ID/EX status and samples the
//                        stall/flush/hold/bubble controls.
//               slave  : controller side.
// Ports       : id_rs1/id_rs2/id_use_rs1/id_use_rs2  ID-stage source usage
//               ex_opcode/ex_rd/branch_taken          EX-stage status
//               pc_stall/if_id_stall/if_id_flush      front-end controls
//               id_ex_hold/id_ex_bubble               ID/EX register controls
//               ex_busy/mul_done/stall_count          status and perf counter
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
  logic [1:0]  id_rs1;
  logic [1:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [3:0]  ex_opcode;
  logic [1:0]  ex_rd;
  logic        branch_taken;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_hold;
  logic        id_ex_bubble;
  logic        ex_busy;
  logic        mul_done;
  logic [15:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_opcode, ex_rd, branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_busy, mul_done, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_opcode, ex_rd, branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_busy, mul_done, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : ID/EX sequencing controller. Inserts a one-cycle bubble on a
//               load-use hazard, holds the pipeline while a multi-cycle
//               multiply occupies EX, flushes younger work on a taken branch
//               and keeps a saturating count of PC stall cycles.
// Ports       : clk      rising-edge clock
//               reset_n  asynchronous active-low reset
//               bus      pipe_hazard_ctrl_if.slave (see interface header)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter logic [3:0] NOP_OPCODE  = 4'b0000,
  parameter logic [3:0] LOAD_OPCODE = 4'b1000,
  parameter logic [3:0] MUL_OPCODE  = 4'b0110,
  parameter int         MUL_CYCLES  = 3
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // Counter preload on entry to MUL_BUSY: the RUN cycle is the first EX
  // cycle and the cnt==0 cycle is the last, so MUL_CYCLES-2 remain between.
  localparam logic [3:0] C_MUL_INIT = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;
  localparam bit         C_MUL_MULTI = (MUL_CYCLES > 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_stall_count;

  state_t      w_next_state;
  logic [3:0]  w_next_cnt;
  logic        w_ex_valid;
  logic        w_is_mul;
  logic        w_load_use;
  logic        w_pc_stall;
  logic        w_if_id_stall;
  logic        w_if_id_flush;
  logic        w_id_ex_hold;
  logic        w_id_ex_bubble;
  logic        w_ex_busy;
  logic        w_mul_done;

  assign w_ex_valid = (bus.ex_opcode != NOP_OPCODE);
  assign w_is_mul   = (bus.ex_opcode == MUL_OPCODE);
  assign w_load_use = w_ex_valid && (bus.ex_opcode == LOAD_OPCODE) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_hold   = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_ex_busy      = 1'b0;
    w_mul_done     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_is_mul) begin
          if (C_MUL_MULTI) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_hold  = 1'b1;
            w_next_state  = MUL_BUSY;
            w_next_cnt    = C_MUL_INIT;
          end else begin
            w_mul_done = 1'b1;
          end
        end else if (bus.branch_taken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
          // The bubble replaces the load in EX, so this clears next cycle.
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        // Branch and load-use cannot resolve while the multiply owns EX.
        w_ex_busy = 1'b1;
        if (r_cnt != 4'd0) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_hold  = 1'b1;
          w_next_cnt    = r_cnt - 4'd1;
        end else begin
          // Hold released: ID/EX takes the next instruction on this edge.
          w_mul_done   = 1'b1;
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_cnt         <= 4'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_pc_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign bus.pc_stall     = reset_n & w_pc_stall;
  assign bus.if_id_stall  = reset_n & w_if_id_stall;
  assign bus.if_id_flush  = reset_n & w_if_id_flush;
  assign bus.id_ex_hold   = reset_n & w_id_ex_hold;
  assign bus.id_ex_bubble = reset_n & w_id_ex_bubble;
  assign bus.ex_busy      = reset_n & w_ex_busy;
  assign bus.mul_done     = reset_n & w_mul_done;
  assign bus.stall_count  = reset_n ? r_stall_count : 16'd0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_BR   = 4'b1100;

  // Control vector order:
  // {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble, ex_busy, mul_done}
  localparam logic [6:0] E_NONE   = 7'b0000000;
  localparam logic [6:0] E_LDUSE  = 7'b1100100;
  localparam logic [6:0] E_BRANCH = 7'b0010100;
  localparam logic [6:0] E_MUL1   = 7'b1101000;
  localparam logic [6:0] E_MULBSY = 7'b1101010;
  localparam logic [6:0] E_MULDN  = 7'b0000011;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [15:0] sc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;
  logic [15:0] exp_sc;
  exp_t sb[$];

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .NOP_OPCODE (OP_NOP),
    .LOAD_OPCODE(OP_LOAD),
    .MUL_OPCODE (OP_MUL),
    .MUL_CYCLES (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_in(input logic [3:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic u1,
                        input logic [1:0] rs2, input logic u2, input logic br);
    bus.ex_opcode    = op;
    bus.ex_rd        = rd;
    bus.id_rs1       = rs1;
    bus.id_use_rs1   = u1;
    bus.id_rs2       = rs2;
    bus.id_use_rs2   = u2;
    bus.branch_taken = br;
  endtask

  task automatic push_exp(input logic [6:0] ctl);
    exp_t e;
    e.ctl = ctl;
    e.sc  = exp_sc;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t       e;
    logic [6:0] obs;
    total++;
    assert (sb.size() != 0) passed++;
    else $error("FAIL %s sb: observed empty scoreboard expected entry", tag);
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_hold,
             bus.id_ex_bubble, bus.ex_busy, bus.mul_done};
      total++;
      assert (obs === e.ctl) passed++;
      else $error("FAIL %s ctl: observed %b expected %b", tag, obs, e.ctl);
      total++;
      assert (bus.stall_count === e.sc) passed++;
      else $error("FAIL %s stall_count: observed %h expected %h", tag, bus.stall_count, e.sc);
      total++;
      assert (!(bus.id_ex_hold && bus.id_ex_bubble) && !(bus.if_id_stall && bus.if_id_flush)) passed++;
      else $error("FAIL %s mutex: observed ctl %b expected exclusive hold/bubble, stall/flush", tag, obs);
    end
  endtask

  // One clock cycle with inputs already driven: compare at the falling edge,
  // then advance the bench's own stall-count model across the rising edge.
  task automatic step(input string tag, input logic [6:0] ctl);
    push_exp(ctl);
    @(negedge clk);
    check_out(tag);
    @(posedge clk);
    if (reset_n && ctl[6] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    #1;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    exp_sc  = 16'd0;
    reset_n = 1'b0;
    set_in(OP_LOAD, 2'd2, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset: hazard present but every output must stay low.
    step("reset_state", E_NONE);
    reset_n = 1'b1;

    // T2 no hazard: register matches but is not used.
    set_in(OP_LOAD, 2'd2, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0);
    step("no_hazard_unused", E_NONE);
    set_in(OP_LOAD, 2'd2, 2'd3, 1'b1, 2'd1, 1'b1, 1'b0);
    step("no_hazard_regdiff", E_NONE);

    // T1 load-use on rs1, then bubble arrives in EX.
    set_in(OP_LOAD, 2'd2, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    step("lduse_rs1", E_LDUSE);
    set_in(OP_NOP, 2'd0, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    step("lduse_rs1_after", E_NONE);

    // Load-use through rs2.
    set_in(OP_LOAD, 2'd1, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0);
    step("lduse_rs2", E_LDUSE);
    set_in(OP_NOP, 2'd0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0);
    step("lduse_rs2_after", E_NONE);

    // T4 branch, and branch taking priority over a load-use.
    set_in(OP_BR, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    step("branch", E_BRANCH);
    set_in(OP_LOAD, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1);
    step("branch_over_lduse", E_BRANCH);

    // T3 multiply, then a back-to-back multiply. Branch/load-use noise while busy.
    set_in(OP_MUL, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step("mul_a_c1", E_MUL1);
    set_in(OP_MUL, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    step("mul_a_c2", E_MULBSY);
    step("mul_a_c3", E_MULDN);
    set_in(OP_MUL, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step("mul_b_c1", E_MUL1);
    step("mul_b_c2", E_MULBSY);
    step("mul_b_c3", E_MULDN);
    set_in(OP_NOP, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step("after_mul", E_NONE);

    // T5 reset on the last MUL_BUSY cycle: outputs drop at once, no mul_done.
    set_in(OP_MUL, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step("mul_r_c1", E_MUL1);
    step("mul_r_c2", E_MULBSY);
    reset_n = 1'b0;
    exp_sc  = 16'd0;
    #1;
    push_exp(E_NONE);
    check_out("async_reset");
    step("reset_held", E_NONE);
    set_in(OP_NOP, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("post_reset_run", E_NONE);
    set_in(OP_MUL, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step("mul_p_c1", E_MUL1);
    step("mul_p_c2", E_MULBSY);
    step("mul_p_c3", E_MULDN);

    // T6 saturation: a persistent load-use hazard stalls every cycle.
    set_in(OP_LOAD, 2'd2, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    exp_sc = ((32'(exp_sc) + 32'd65540) > 32'hFFFF) ? 16'hFFFF : 16'(32'(exp_sc) + 32'd65540);
    #1;
    step("sat_1", E_LDUSE);
    step("sat_2", E_LDUSE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
